// File: rtl/p3_pkg.sv
// Shared types for the 3-wire permutation sequencer.
// Optional macro P3_SEQ_PARITY_EN widens each LIFO entry to {ctrl, ~ctrl}.
package p3_pkg;

    typedef enum logic {P3_FWD, P3_BWD} p3_phase_e;

    typedef logic [2:0] p3_tri_t;

    typedef struct packed {
        logic    ctrl;
        p3_tri_t data;
    } p3_beat_t;

`ifdef P3_SEQ_PARITY_EN
    localparam int P3_ENTRY_W = 2;
`else
    localparam int P3_ENTRY_W = 1;
`endif

    // Build a LIFO entry from a control bit; ctrl always sits in the MSB.
    function automatic logic [P3_ENTRY_W-1:0] p3_encode(input logic c);
`ifdef P3_SEQ_PARITY_EN
        return {c, ~c};
`else
        return c;
`endif
    endfunction

endpackage

// File: rtl/p3_lifo.sv
// Small LIFO holding the forward control history of one batch.
// Push and pop are never requested in the same cycle by the owner.
module p3_lifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = count[AW-1:0];
    assign rd_idx = AW'(count - ONE);
    assign top    = mem[rd_idx];

    // Entry storage; contents are simply abandoned on reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (push) begin
            count <= count + ONE;
        end else if (pop) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/p3_ctrl_sequencer.sv
// Forward/backward beat sequencer feeding the controlled-permutation stage.
// Define P3_SEQ_PARITY_EN to store ~ctrl per entry and flag corrupt pops on err_out.
module p3_ctrl_sequencer
    import p3_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             fwd_valid_in,
    output logic             fwd_ready_out,
    input  logic             fwd_ctrl_in,
    input  logic [2:0]       fwd_data_in,
    input  logic             bwd_start_in,
    input  logic             bwd_valid_in,
    output logic             bwd_ready_out,
    input  logic [2:0]       bwd_data_in,
    output logic             ctrl_out,
    output logic [2:0]       fdata_out,
    output logic [2:0]       bdata_out,
    output logic             fwd_out_valid,
    output logic             bwd_out_valid,
    output logic             bwd_done_out,
    output logic [CNT_W-1:0] count_out,
    output logic             err_out
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    p3_phase_e             state;
    p3_phase_e             state_nxt;
    p3_beat_t              fin;
    logic                  fwd_acc;
    logic                  bwd_acc;
    logic                  done_nxt;
    logic [P3_ENTRY_W-1:0] top;
    logic [CNT_W-1:0]      count;

    assign fin       = '{ctrl: fwd_ctrl_in, data: fwd_data_in};
    assign count_out = count;

    p3_lifo #(
        .DEPTH (DEPTH),
        .WIDTH (P3_ENTRY_W)
    ) u_lifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (fwd_acc),
        .pop   (bwd_acc),
        .din   (p3_encode(fin.ctrl)),
        .top   (top),
        .count (count)
    );

    // Phase register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= P3_FWD;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshakes and phase transitions; a same-cycle push counts toward leaving FWD.
    always_comb begin
        state_nxt     = state;
        fwd_ready_out = 1'b0;
        bwd_ready_out = 1'b0;
        fwd_acc       = 1'b0;
        bwd_acc       = 1'b0;
        done_nxt      = 1'b0;
        unique case (state)
            P3_FWD: begin
                fwd_ready_out = (count != FULL);
                fwd_acc       = fwd_valid_in & fwd_ready_out;
                if (bwd_start_in) begin
                    if ((count != '0) || fwd_acc) begin
                        state_nxt = P3_BWD;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            P3_BWD: begin
                bwd_ready_out = (count != '0);
                bwd_acc       = bwd_valid_in & bwd_ready_out;
                if (bwd_acc && (count == ONE)) begin
                    state_nxt = P3_FWD;
                    done_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers: data holds between pulses, valids are single-cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ctrl_out      <= 1'b0;
            fdata_out     <= '0;
            bdata_out     <= '0;
            fwd_out_valid <= 1'b0;
            bwd_out_valid <= 1'b0;
            bwd_done_out  <= 1'b0;
        end else begin
            fwd_out_valid <= fwd_acc;
            bwd_out_valid <= bwd_acc;
            bwd_done_out  <= done_nxt;
            if (fwd_acc) begin
                ctrl_out  <= fin.ctrl;
                fdata_out <= fin.data;
            end else if (bwd_acc) begin
                ctrl_out  <= top[P3_ENTRY_W-1];
                bdata_out <= bwd_data_in;
            end
        end
    end

`ifdef P3_SEQ_PARITY_EN
    logic err_q;

    // Sticky flag: a popped entry whose two copies agree was corrupted.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else if (bwd_acc && (top[1] == top[0])) begin
            err_q <= 1'b1;
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_p3_ctrl_sequencer.sv
// Self-checking bench for p3_ctrl_sequencer: directed batches plus a
// randomized run compared every cycle against a queue-based model.
module tb_p3_ctrl_sequencer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             fwd_valid_in;
    logic             fwd_ready_out;
    logic             fwd_ctrl_in;
    logic [2:0]       fwd_data_in;
    logic             bwd_start_in;
    logic             bwd_valid_in;
    logic             bwd_ready_out;
    logic [2:0]       bwd_data_in;
    logic             ctrl_out;
    logic [2:0]       fdata_out;
    logic [2:0]       bdata_out;
    logic             fwd_out_valid;
    logic             bwd_out_valid;
    logic             bwd_done_out;
    logic [CNT_W-1:0] count_out;
    logic             err_out;

    always #5 clk_in = ~clk_in;

    p3_ctrl_sequencer #(.DEPTH(DEPTH)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .fwd_valid_in  (fwd_valid_in),
        .fwd_ready_out (fwd_ready_out),
        .fwd_ctrl_in   (fwd_ctrl_in),
        .fwd_data_in   (fwd_data_in),
        .bwd_start_in  (bwd_start_in),
        .bwd_valid_in  (bwd_valid_in),
        .bwd_ready_out (bwd_ready_out),
        .bwd_data_in   (bwd_data_in),
        .ctrl_out      (ctrl_out),
        .fdata_out     (fdata_out),
        .bdata_out     (bdata_out),
        .fwd_out_valid (fwd_out_valid),
        .bwd_out_valid (bwd_out_valid),
        .bwd_done_out  (bwd_done_out),
        .count_out     (count_out),
        .err_out       (err_out)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Behavioural model: a stack of ctrl bits plus a forward/backward phase flag.
    bit         q[$];
    bit         m_fwd  = 1'b1;
    logic       e_ctrl = 1'b0;
    logic [2:0] e_fd   = '0;
    logic [2:0] e_bd   = '0;
    logic       e_fv   = 1'b0;
    logic       e_bv   = 1'b0;
    logic       e_done = 1'b0;
    bit         fa;
    bit         ba;
    bit         popped;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            q.delete();
            m_fwd  = 1'b1;
            e_ctrl = 1'b0;
            e_fd   = '0;
            e_bd   = '0;
            e_fv   = 1'b0;
            e_bv   = 1'b0;
            e_done = 1'b0;
        end else begin
            fa     = fwd_valid_in && m_fwd && (q.size() < DEPTH);
            ba     = bwd_valid_in && !m_fwd && (q.size() > 0);
            e_fv   = fa;
            e_bv   = ba;
            e_done = 1'b0;
            if (fa) begin
                q.push_back(fwd_ctrl_in);
                e_ctrl = fwd_ctrl_in;
                e_fd   = fwd_data_in;
            end
            if (m_fwd && bwd_start_in) begin
                if (q.size() > 0) m_fwd = 1'b0;
                else e_done = 1'b1;
            end
            if (ba) begin
                popped = q.pop_back();
                e_ctrl = popped;
                e_bd   = bwd_data_in;
                if (q.size() == 0) begin
                    e_done = 1'b1;
                    m_fwd  = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        chk("fwd_ready", fwd_ready_out, m_fwd && (q.size() < DEPTH));
        chk("bwd_ready", bwd_ready_out, !m_fwd && (q.size() > 0));
        chk("ctrl_out", ctrl_out, e_ctrl);
        chk("fdata_out", fdata_out, e_fd);
        chk("bdata_out", bdata_out, e_bd);
        chk("fwd_out_valid", fwd_out_valid, e_fv);
        chk("bwd_out_valid", bwd_out_valid, e_bv);
        chk("bwd_done", bwd_done_out, e_done);
        chk("count_out", count_out, q.size());
        chk("err_out", err_out, 0);
    end

    task automatic cyc(input bit fv, input bit fc, input logic [2:0] fd,
                       input bit bs, input bit bv, input logic [2:0] bd);
        @(negedge clk_in);
        #1;
        fwd_valid_in = fv;
        fwd_ctrl_in  = fc;
        fwd_data_in  = fd;
        bwd_start_in = bs;
        bwd_valid_in = bv;
        bwd_data_in  = bd;
    endtask

    task automatic idle();
        cyc(0, 0, 3'b000, 0, 0, 3'b000);
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        #1;
        rst_in       = 1'b1;
        fwd_valid_in = 1'b0;
        bwd_start_in = 1'b0;
        bwd_valid_in = 1'b0;
        @(negedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in       = 1'b0;
        fwd_valid_in = 1'b0;
        fwd_ctrl_in  = 1'b0;
        fwd_data_in  = '0;
        bwd_start_in = 1'b0;
        bwd_valid_in = 1'b0;
        bwd_data_in  = '0;
        #1 rst_in = 1'b1;
        #1;
        chk("rst_fwd_ready", fwd_ready_out, 1);
        chk("rst_bwd_ready", bwd_ready_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_outs", {ctrl_out, fdata_out, bdata_out, fwd_out_valid,
                         bwd_out_valid, bwd_done_out, err_out}, 0);
        @(negedge clk_in);
        #1 rst_in = 1'b0;

        // Forward beats 1/000, 0/010, 1/111.
        cyc(1, 1, 3'b000, 0, 0, 3'b000);
        cyc(1, 0, 3'b010, 0, 0, 3'b000);
        chk("f1_ctrl", {fwd_out_valid, ctrl_out, fdata_out}, 5'b1_1_000);
        cyc(1, 1, 3'b111, 0, 0, 3'b000);
        chk("f2_ctrl", {fwd_out_valid, ctrl_out, fdata_out}, 5'b1_0_010);
        idle();
        chk("f3_ctrl", {fwd_out_valid, ctrl_out, fdata_out}, 5'b1_1_111);
        chk("f3_count", count_out, 3);

        // Backward replay in reverse order.
        cyc(0, 0, 3'b000, 1, 0, 3'b000);
        cyc(0, 0, 3'b000, 0, 1, 3'b110);
        chk("b_ready", bwd_ready_out, 1);
        cyc(0, 0, 3'b000, 0, 1, 3'b001);
        chk("b1", {bwd_out_valid, bwd_done_out, ctrl_out, bdata_out}, 6'b10_1_110);
        cyc(0, 0, 3'b000, 0, 1, 3'b011);
        chk("b2", {bwd_out_valid, bwd_done_out, ctrl_out, bdata_out}, 6'b10_0_001);
        idle();
        chk("b3", {bwd_out_valid, bwd_done_out, ctrl_out, bdata_out}, 6'b11_1_011);
        idle();
        chk("b_back_fwd", {fwd_ready_out, bwd_ready_out, count_out}, 6'b10_0000);

        // Fill to DEPTH with valid held; the ninth beat stalls.
        for (int i = 0; i < DEPTH + 1; i++) begin
            cyc(1, i[0], i[2:0], 0, 0, 3'b000);
        end
        idle();
        chk("full_count", count_out, DEPTH);
        chk("full_ready", {fwd_ready_out, fwd_out_valid}, 2'b00);
        cyc(0, 0, 3'b000, 1, 0, 3'b000);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 3'b000, 0, 1, 3'($urandom));
        end
        idle();
        idle();
        chk("drained", count_out, 0);

        // Start with nothing stored, then push+start together.
        cyc(0, 0, 3'b000, 1, 0, 3'b000);
        idle();
        chk("empty_done", {bwd_done_out, bwd_out_valid}, 2'b10);
        idle();
        chk("empty_done_off", bwd_done_out, 0);
        cyc(1, 1, 3'b101, 1, 0, 3'b000);
        idle();
        chk("same_cyc", {count_out, bwd_ready_out, fwd_ready_out}, 6'b0001_10);

        // Async reset mid-backward with two entries left.
        pulse_reset();
        cyc(1, 0, 3'b001, 0, 0, 3'b000);
        cyc(1, 1, 3'b010, 0, 0, 3'b000);
        cyc(1, 1, 3'b100, 1, 0, 3'b000);
        cyc(0, 0, 3'b000, 0, 1, 3'b111);
        idle();
        chk("mid_count", count_out, 2);
        rst_in = 1'b1;
        #1;
        chk("mid_rst", {count_out, fwd_ready_out, bwd_ready_out, ctrl_out,
                        bdata_out}, 10'b0000_1_0_0_000);
        @(negedge clk_in);
        #1 rst_in = 1'b0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 6, 1'($urandom), 3'($urandom),
                $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6,
                3'($urandom));
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end
        idle();
        @(negedge clk_in);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
